// File: rtl/vec_collect_if.sv
// Stream-in / vector-out bundle between an element producer, vec_collect and the min-search stage.
// Latency: none; wires only.
// Backpressure: io_in_ready throttles the producer, io_out_ready holds the assembled vector.
interface vec_collect_if #(
    parameter int W = 8
);
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_bits;
    logic         io_flush;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_vec_0;
    logic [W-1:0] io_vec_1;
    logic [W-1:0] io_vec_2;
    logic [W-1:0] io_vec_3;
    logic [W-1:0] io_vec_4;
    logic [W-1:0] io_vec_5;
    logic [W-1:0] io_vec_6;
    logic [W-1:0] io_vec_7;
    logic [W-1:0] io_vec_8;
    logic [W-1:0] io_vec_9;
    logic [W-1:0] io_min_v;
    logic [7:0]   io_min_idx;

    // Producer/consumer side: drives the element stream, flush and the vector accept.
    modport master (
        output io_in_valid, io_in_bits, io_flush, io_out_ready,
        input  io_in_ready, io_out_valid,
        input  io_vec_0, io_vec_1, io_vec_2, io_vec_3, io_vec_4,
        input  io_vec_5, io_vec_6, io_vec_7, io_vec_8, io_vec_9,
        input  io_min_v, io_min_idx
    );

    // Collector side.
    modport slave (
        input  io_in_valid, io_in_bits, io_flush, io_out_ready,
        output io_in_ready, io_out_valid,
        output io_vec_0, io_vec_1, io_vec_2, io_vec_3, io_vec_4,
        output io_vec_5, io_vec_6, io_vec_7, io_vec_8, io_vec_9,
        output io_min_v, io_min_idx
    );
endinterface

// File: rtl/vec_collect.sv
// Serial-to-parallel loader: gathers 10 stream elements into a registered vector for the min search.
// Latency: out_valid is seen the cycle after the 10th accept; one vector per 11 cycles at full rate.
// Backpressure: in_ready=0 while a vector is held; the vector stays frozen until out_ready (no bypass).
// Optional build macro VEC_COLLECT_RUNNING_MIN_EN adds a running min value/index tracker.
module vec_collect #(
    parameter int N = 10,
    parameter int W = 8
) (
    input  logic          clock,
    input  logic          reset,
    vec_collect_if.slave  bus
);
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic         wr_en;
    logic [W-1:0] vec_q [N];

    // Handshake outputs come from the state alone, never from the partner's valid/ready.
    assign bus.io_in_ready  = (state_q == FILL);
    assign bus.io_out_valid = (state_q == FULL);

    // State register and fill counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, next count and element write enable; flush overrides accept and drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.io_in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = 4'd0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            FULL: begin
                if (bus.io_out_ready) begin
                    state_d = FILL;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = 4'd0;
            end
        endcase
        if (bus.io_flush) begin
            state_d = FILL;
            cnt_d   = 4'd0;
            wr_en   = 1'b0;
        end
    end

    // Element store: write slot cnt on an accepted element; contents survive flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                vec_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                if (cnt_q == 4'(k)) begin
                    vec_q[k] <= bus.io_in_bits;
                end
            end
        end
    end

    assign bus.io_vec_0 = vec_q[0];
    assign bus.io_vec_1 = vec_q[1];
    assign bus.io_vec_2 = vec_q[2];
    assign bus.io_vec_3 = vec_q[3];
    assign bus.io_vec_4 = vec_q[4];
    assign bus.io_vec_5 = vec_q[5];
    assign bus.io_vec_6 = vec_q[6];
    assign bus.io_vec_7 = vec_q[7];
    assign bus.io_vec_8 = vec_q[8];
    assign bus.io_vec_9 = vec_q[9];

`ifdef VEC_COLLECT_RUNNING_MIN_EN
    logic [W-1:0] min_v_q;
    logic [3:0]   min_idx_q;

    // Running minimum; first element seeds it, strict compare keeps the earliest index on ties.
    always_ff @(posedge clock) begin
        if (reset || bus.io_flush) begin
            min_v_q   <= '0;
            min_idx_q <= 4'd0;
        end else if (wr_en) begin
            if ((cnt_q == 4'd0) || (bus.io_in_bits < min_v_q)) begin
                min_v_q   <= bus.io_in_bits;
                min_idx_q <= cnt_q;
            end
        end
    end

    assign bus.io_min_v   = min_v_q;
    assign bus.io_min_idx = {4'd0, min_idx_q};
`else
    assign bus.io_min_v   = '0;
    assign bus.io_min_idx = 8'd0;
`endif

endmodule

// File: tb/tb_vec_collect.sv
// Bench for vec_collect: directed scenarios plus a random soak against a queue-based model.
// Latency: checks outputs each cycle from the model's view of the held vector.
// Backpressure: exercises out_ready low, drain-cycle offers, flush and mid-stream reset.
module tb_vec_collect;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    vec_collect_if ifc ();

    vec_collect dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    logic [7:0] dv [10];
    assign dv[0] = ifc.io_vec_0;
    assign dv[1] = ifc.io_vec_1;
    assign dv[2] = ifc.io_vec_2;
    assign dv[3] = ifc.io_vec_3;
    assign dv[4] = ifc.io_vec_4;
    assign dv[5] = ifc.io_vec_5;
    assign dv[6] = ifc.io_vec_6;
    assign dv[7] = ifc.io_vec_7;
    assign dv[8] = ifc.io_vec_8;
    assign dv[9] = ifc.io_vec_9;

    int vectors     = 0;
    int miscompares = 0;

    // Model: elements accepted into the current vector; ten of them means a vector is held.
    logic [7:0] acc [$];

    logic       t_took;
    logic       t_ov;
    logic [7:0] seq [20];
    logic [7:0] min_seq [10];
    int         idx;
    int         ov_count;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic       full;
        logic [7:0] mv;
        logic [7:0] mi;
        full = (acc.size() == 10);
        chk("in_ready", 8'(ifc.io_in_ready), 8'(!full));
        chk("out_valid", 8'(ifc.io_out_valid), 8'(full));
        if (full) begin
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("vec_%0d", k), dv[k], acc[k]);
            end
`ifdef VEC_COLLECT_RUNNING_MIN_EN
            mv = acc[0];
            mi = 8'd0;
            for (int k = 1; k < 10; k++) begin
                if (acc[k] < mv) begin
                    mv = acc[k];
                    mi = 8'(k);
                end
            end
            chk("min_v", ifc.io_min_v, mv);
            chk("min_idx", ifc.io_min_idx, mi);
`endif
        end
`ifndef VEC_COLLECT_RUNNING_MIN_EN
        mv = 8'd0;
        mi = 8'd0;
        chk("min_v_off", ifc.io_min_v, mv);
        chk("min_idx_off", ifc.io_min_idx, mi);
`endif
    endtask

    // One clock cycle: drive, check pre-edge outputs, then advance the model on the edge.
    task automatic step(input logic v, input logic [7:0] b, input logic fl, input logic ordy,
                        output logic took, output logic ov);
        logic was_full;
        @(negedge clock);
        ifc.io_in_valid  = v;
        ifc.io_in_bits   = b;
        ifc.io_flush     = fl;
        ifc.io_out_ready = ordy;
        #1;
        check_outputs();
        ov       = ifc.io_out_valid;
        was_full = (acc.size() == 10);
        @(posedge clock);
        took = 1'b0;
        if (fl) begin
            acc.delete();
        end else if (!was_full && v) begin
            acc.push_back(b);
            took = 1'b1;
        end else if (was_full && ordy) begin
            acc.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset            = 1'b1;
        ifc.io_in_valid  = 1'b1;
        ifc.io_in_bits   = 8'($urandom);
        ifc.io_flush     = 1'b0;
        ifc.io_out_ready = 1'b0;
        @(posedge clock);
        acc.delete();
        #1;
        chk("rst_in_ready", 8'(ifc.io_in_ready), 8'd1);
        chk("rst_out_valid", 8'(ifc.io_out_valid), 8'd0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("rst_vec_%0d", k), dv[k], 8'd0);
        end
        chk("rst_min_v", ifc.io_min_v, 8'd0);
        chk("rst_min_idx", ifc.io_min_idx, 8'd0);
        @(negedge clock);
        reset           = 1'b0;
        ifc.io_in_valid = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        ifc.io_in_valid  = 1'b0;
        ifc.io_in_bits   = 8'd0;
        ifc.io_flush     = 1'b0;
        ifc.io_out_ready = 1'b0;
        do_reset();

        // Fill 10..100 with the consumer stalled, then hold for 20 cycles while offering junk.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(10 * (i + 1)), 1'b0, 1'b0, t_took, t_ov);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 8'($urandom), 1'b0, 1'b0, t_took, t_ov);
        end
        #1;
        chk("hold_vec0", dv[0], 8'd10);
        chk("hold_vec9", dv[9], 8'd100);
        step(1'b0, 8'd0, 1'b0, 1'b1, t_took, t_ov);

        // Two back-to-back vectors at full rate; the drain-cycle element must be re-presented.
        for (int i = 0; i < 20; i++) begin
            seq[i] = 8'($urandom);
        end
        idx      = 0;
        ov_count = 0;
        for (int c = 0; c < 22; c++) begin
            step(1'b1, seq[idx], 1'b0, 1'b1, t_took, t_ov);
            if (t_took) idx++;
            if (t_ov) ov_count++;
        end
        chk("cont_out_valid_cycles", 8'(ov_count), 8'd2);
        chk("cont_accepted", 8'(idx), 8'd20);

        // Partial vector, flush with an element offered, then a clean 1..10 vector.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, t_took, t_ov);
        end
        step(1'b1, 8'hEE, 1'b1, 1'b0, t_took, t_ov);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, t_took, t_ov);
        end
        #1;
        chk("flush_vec0", dv[0], 8'h01);
        chk("flush_vec4", dv[4], 8'h05);
        chk("flush_vec9", dv[9], 8'h0A);
        step(1'b0, 8'd0, 1'b0, 1'b1, t_took, t_ov);

        // Running-minimum sequence with ties; then flush colliding with a drain.
        min_seq = '{8'd9, 8'd5, 8'd7, 8'd5, 8'd3, 8'd3, 8'd8, 8'd200, 8'd255, 8'd4};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, min_seq[i], 1'b0, 1'b0, t_took, t_ov);
        end
        #1;
`ifdef VEC_COLLECT_RUNNING_MIN_EN
        chk("minseq_v", ifc.io_min_v, 8'h03);
        chk("minseq_idx", ifc.io_min_idx, 8'd4);
`else
        chk("minseq_v", ifc.io_min_v, 8'h00);
        chk("minseq_idx", ifc.io_min_idx, 8'd0);
`endif
        step(1'b1, 8'h55, 1'b1, 1'b1, t_took, t_ov);
        step(1'b0, 8'd0, 1'b0, 1'b0, t_took, t_ov);

        // Reset while a vector is held.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, t_took, t_ov);
        end
        do_reset();

        // Valid gaps over 0xFF,0x00,... : ten accepts across twenty cycles.
        for (int i = 0; i < 20; i++) begin
            step(1'(i % 2 == 0), ((i / 2) % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0, t_took, t_ov);
        end
        #1;
        chk("gap_out_valid", 8'(ifc.io_out_valid), 8'd1);
        chk("gap_vec1", dv[1], 8'h00);
        chk("gap_vec8", dv[8], 8'hFF);
        step(1'b0, 8'd0, 1'b0, 1'b1, t_took, t_ov);

        // Random soak.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 22) == 0),
                 1'($urandom_range(0, 2) != 0), t_took, t_ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
